regmem_ctrl: RTL and testbench

REGMEM_CTRL -- requirements
Module: regmem_ctrl

---
 rtl/regmem_ctrl.sv | 152 +++++++++++++++
 tb/tb_regmem_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regmem_ctrl.sv
// Command-driven register file / memory controller. Memory commands finish MEM_LAT
// cycles after acceptance and register commands finish after one cycle; each completion pulses out_valid.
module regmem_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned REG_N   = 16,
  parameter int unsigned MEM_N   = 16,
  parameter int unsigned MEM_LAT = 2,
  localparam int unsigned RA_W = (REG_N > 1) ? $clog2(REG_N) : 1,
  localparam int unsigned MA_W = (MEM_N > 1) ? $clog2(MEM_N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [RA_W-1:0]   ra,
  input  logic [MA_W-1:0]   maddr,
  input  logic [DATA_W-1:0] imm,
  output logic              out_valid,
  output logic [DATA_W-1:0] res,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    REG_EXEC = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [RA_W-1:0]     ra_q, ra_d;
  logic [MA_W-1:0]     maddr_q, maddr_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic                out_valid_q, out_valid_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [DATA_W-1:0]   regs_q [REG_N];
  logic [DATA_W-1:0]   regs_d [REG_N];
  logic [DATA_W-1:0]   mem_q  [MEM_N];
  logic [DATA_W-1:0]   mem_d  [MEM_N];
  logic [RA_W-1:0]     ra_wrap;
  logic [MA_W-1:0]     maddr_wrap;
  logic [DATA_W-1:0]   reg_rd;
  logic [DATA_W-1:0]   mem_rd;
  logic                done;

  // Indices are folded at capture so every later array access is in range.
  assign ra_wrap    = RA_W'(32'(ra) % REG_N);
  assign maddr_wrap = MA_W'(32'(maddr) % MEM_N);

  assign reg_rd = regs_q[ra_q];
  assign mem_rd = mem_q[maddr_q];

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign res       = res_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    ra_d        = ra_q;
    maddr_d     = maddr_q;
    imm_d       = imm_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    res_d       = res_q;
    regs_d      = regs_q;
    mem_d       = mem_q;
    done        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = op;
          ra_d    = ra_wrap;
          maddr_d = maddr_wrap;
          imm_d   = imm;
          if (!op[2]) begin
            state_d = MEM_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = REG_EXEC;
          end
        end
      end
      MEM_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REG_EXEC: begin
        state_d = IDLE;
        done    = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Results use pre-write array contents, so res reflects state before the commit.
    if (done) begin
      out_valid_d = 1'b1;
      case (op_q)
        3'b000: begin mem_d[maddr_q] = imm_q;  res_d = imm_q;  end
        3'b001: begin mem_d[maddr_q] = reg_rd; res_d = reg_rd; end
        3'b010: begin regs_d[ra_q]   = mem_rd; res_d = mem_rd; end
        3'b011: res_d = mem_rd;
        3'b100: begin regs_d[ra_q]   = imm_q;  res_d = imm_q;  end
        3'b101: res_d = reg_rd;
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      ra_q        <= '0;
      maddr_q     <= '0;
      imm_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      res_q       <= '0;
      for (int unsigned i = 0; i < REG_N; i++) regs_q[i] <= '0;
      for (int unsigned i = 0; i < MEM_N; i++) mem_q[i]  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      ra_q        <= ra_d;
      maddr_q     <= maddr_d;
      imm_q       <= imm_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      res_q       <= res_d;
      regs_q      <= regs_d;
      mem_q       <= mem_d;
    end
  end

endmodule

// File: tb/tb_regmem_ctrl.sv
// Directed bench for regmem_ctrl: default build, MEM_LAT=4/DATA_W=16 build,
// and a non-power-of-two depth build with MEM_LAT=1.
module tb_regmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iv_a = 1'b0, iv_b = 1'b0, iv_c = 1'b0;
  logic [2:0]  op = '0;
  logic [3:0]  ra = '0;
  logic [3:0]  maddr = '0;
  logic [15:0] imm = '0;

  logic        in_ready_a, out_valid_a, err_a, busy_a;
  logic [7:0]  res_a;
  logic        in_ready_b, out_valid_b, err_b, busy_b;
  logic [15:0] res_b;
  logic        in_ready_c, out_valid_c, err_c, busy_c;
  logic [7:0]  res_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regmem_ctrl u_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(in_ready_a), .op(op),
    .ra(ra), .maddr(maddr), .imm(imm[7:0]), .out_valid(out_valid_a),
    .res(res_a), .err(err_a), .busy(busy_a)
  );

  regmem_ctrl #(.DATA_W(16), .MEM_LAT(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(in_ready_b), .op(op),
    .ra(ra), .maddr(maddr), .imm(imm), .out_valid(out_valid_b),
    .res(res_b), .err(err_b), .busy(busy_b)
  );

  regmem_ctrl #(.REG_N(12), .MEM_N(10), .MEM_LAT(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(iv_c), .in_ready(in_ready_c), .op(op),
    .ra(ra), .maddr(maddr), .imm(imm[7:0]), .out_valid(out_valid_c),
    .res(res_c), .err(err_c), .busy(busy_c)
  );

  // Drives one command to the selected instance and reports cycles to out_valid (-1 on timeout).
  task automatic send(input int sel, input logic [2:0] o, input logic [3:0] r,
                      input logic [3:0] m, input logic [15:0] i,
                      output int lat, output logic [15:0] rv, output logic ev,
                      output logic rdy);
    logic ov;
    @(negedge clk);
    op = o; ra = r; maddr = m; imm = i;
    case (sel)
      0:       iv_a = 1'b1;
      1:       iv_b = 1'b1;
      default: iv_c = 1'b1;
    endcase
    @(posedge clk); #1;
    iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
    op = ~o; ra = ~r; maddr = ~m; imm = ~i;
    lat = -1; rv = '0; ev = 1'b0; rdy = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      case (sel)
        0:       begin ov = out_valid_a; rv = {8'h00, res_a}; ev = err_a; rdy = in_ready_a; end
        1:       begin ov = out_valid_b; rv = res_b;          ev = err_b; rdy = in_ready_b; end
        default: begin ov = out_valid_c; rv = {8'h00, res_c}; ev = err_c; rdy = in_ready_c; end
      endcase
      if (ov) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({in_ready_a, busy_a, out_valid_a, err_a, res_a} !== {4'b1000, 8'h00}) begin
      bad++;
      $display("FAIL reset_a got rdy/busy/ov/err=%b res=%h want 1000 res=00",
               {in_ready_a, busy_a, out_valid_a, err_a}, res_a);
    end
    total++;
    if ({in_ready_b, busy_b, out_valid_b, in_ready_c, busy_c, out_valid_c, res_b} !== {6'b100100, 16'h0000}) begin
      bad++;
      $display("FAIL reset_bc got %b res_b=%h want 100100 res_b=0000",
               {in_ready_b, busy_b, out_valid_b, in_ready_c, busy_c, out_valid_c}, res_b);
    end
  endtask

  task automatic test_sti();
    int lat; logic [15:0] rv; logic ev, rdy;
    @(negedge clk);
    op = 3'b000; ra = 4'd0; maddr = 4'd5; imm = 16'd10; iv_a = 1'b1;
    @(posedge clk); #1;
    iv_a = 1'b0; imm = 16'h00FF; maddr = 4'd0;
    total++;
    if ({busy_a, out_valid_a} !== 2'b10) begin
      bad++; $display("FAIL sti_busy_t got busy/ov=%b want 10", {busy_a, out_valid_a});
    end
    @(posedge clk); #1;
    total++;
    if ({busy_a, out_valid_a} !== 2'b10) begin
      bad++; $display("FAIL sti_busy_t1 got busy/ov=%b want 10", {busy_a, out_valid_a});
    end
    @(posedge clk); #1;
    total++;
    if ({out_valid_a, busy_a, in_ready_a, err_a, res_a} !== {4'b1010, 8'd10}) begin
      bad++;
      $display("FAIL sti_done got ov/busy/rdy/err=%b res=%h want 1010 res=0a",
               {out_valid_a, busy_a, in_ready_a, err_a}, res_a);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid_a !== 1'b0) begin
      bad++; $display("FAIL sti_pulse got ov=%b want 0", out_valid_a);
    end
    send(0, 3'b011, 4'd0, 4'd5, 16'd0, lat, rv, ev, rdy);
    total++;
    if (lat !== 2 || rv !== 16'd10) begin
      bad++; $display("FAIL rdm5 got lat=%0d res=%h want lat=2 res=000a", lat, rv);
    end
  endtask

  task automatic test_mem_chain();
    int lat; logic [15:0] rv; logic ev, rdy;
    send(0, 3'b010, 4'd4, 4'd5, 16'd0, lat, rv, ev, rdy);
    total++;
    if (lat !== 2 || rv !== 16'd10) begin
      bad++; $display("FAIL ldr got lat=%0d res=%h want lat=2 res=000a", lat, rv);
    end
    send(0, 3'b001, 4'd4, 4'd11, 16'd0, lat, rv, ev, rdy);
    total++;
    if (lat !== 2 || rv !== 16'd10) begin
      bad++; $display("FAIL str got lat=%0d res=%h want lat=2 res=000a", lat, rv);
    end
    send(0, 3'b011, 4'd0, 4'd11, 16'd0, lat, rv, ev, rdy);
    total++;
    if (lat !== 2 || rv !== 16'd10) begin
      bad++; $display("FAIL rdm11 got lat=%0d res=%h want lat=2 res=000a", lat, rv);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] rv; logic ev, rdy;
    send(0, 3'b100, 4'd3, 4'd0, 16'h00A5, lat, rv, ev, rdy);
    total++;
    if (lat !== 1 || rv !== 16'h00A5 || rdy !== 1'b1) begin
      bad++; $display("FAIL ldi got lat=%0d res=%h rdy=%b want lat=1 res=00a5 rdy=1", lat, rv, rdy);
    end
    send(0, 3'b101, 4'd3, 4'd0, 16'd0, lat, rv, ev, rdy);
    total++;
    if (lat !== 1 || rv !== 16'h00A5 || rdy !== 1'b1) begin
      bad++; $display("FAIL rdr got lat=%0d res=%h rdy=%b want lat=1 res=00a5 rdy=1", lat, rv, rdy);
    end
  endtask

  task automatic test_reserved();
    int lat; logic [15:0] rv; logic ev, rdy;
    send(0, 3'b110, 4'd3, 4'd11, 16'h0055, lat, rv, ev, rdy);
    total++;
    if (lat !== 1 || rv !== 16'h00A5 || ev !== 1'b1) begin
      bad++; $display("FAIL rsv110 got lat=%0d res=%h err=%b want lat=1 res=00a5 err=1", lat, rv, ev);
    end
    send(0, 3'b111, 4'd3, 4'd11, 16'h0066, lat, rv, ev, rdy);
    total++;
    if (lat !== 1 || rv !== 16'h00A5 || ev !== 1'b1) begin
      bad++; $display("FAIL rsv111 got lat=%0d res=%h err=%b want lat=1 res=00a5 err=1", lat, rv, ev);
    end
    send(0, 3'b101, 4'd3, 4'd0, 16'd0, lat, rv, ev, rdy);
    total++;
    if (lat !== 1 || rv !== 16'h00A5 || ev !== 1'b0) begin
      bad++; $display("FAIL rsv_reg got lat=%0d res=%h err=%b want lat=1 res=00a5 err=0", lat, rv, ev);
    end
    send(0, 3'b011, 4'd0, 4'd11, 16'd0, lat, rv, ev, rdy);
    total++;
    if (lat !== 2 || rv !== 16'd10 || ev !== 1'b0) begin
      bad++; $display("FAIL rsv_mem got lat=%0d res=%h err=%b want lat=2 res=000a err=0", lat, rv, ev);
    end
  endtask

  task automatic test_no_stale();
    int lat; logic [15:0] rv; logic ev, rdy;
    send(0, 3'b100, 4'd1, 4'd0, 16'h003C, lat, rv, ev, rdy);
    send(0, 3'b001, 4'd1, 4'd7, 16'd0, lat, rv, ev, rdy);
    send(0, 3'b011, 4'd0, 4'd7, 16'd0, lat, rv, ev, rdy);
    total++;
    if (lat !== 2 || rv !== 16'h003C) begin
      bad++; $display("FAIL stale_rdm got lat=%0d res=%h want lat=2 res=003c", lat, rv);
    end
    send(0, 3'b010, 4'd2, 4'd7, 16'd0, lat, rv, ev, rdy);
    send(0, 3'b101, 4'd2, 4'd0, 16'd0, lat, rv, ev, rdy);
    total++;
    if (lat !== 1 || rv !== 16'h003C) begin
      bad++; $display("FAIL stale_rdr got lat=%0d res=%h want lat=1 res=003c", lat, rv);
    end
  endtask

  task automatic test_abort();
    int lat; logic [15:0] rv; logic ev, rdy;
    int pulses;
    @(negedge clk);
    op = 3'b000; ra = 4'd0; maddr = 4'd2; imm = 16'd7; iv_a = 1'b1;
    @(posedge clk); #1;
    iv_a = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    pulses = out_valid_a ? 1 : 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid_a) pulses++;
    end
    total++;
    if (pulses !== 0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL abort got pulses=%0d busy=%b want pulses=0 busy=0", pulses, busy_a);
    end
    send(0, 3'b011, 4'd0, 4'd2, 16'd0, lat, rv, ev, rdy);
    total++;
    if (lat !== 2 || rv !== 16'd0) begin
      bad++; $display("FAIL abort_rdm2 got lat=%0d res=%h want lat=2 res=0000", lat, rv);
    end
    send(0, 3'b011, 4'd0, 4'd5, 16'd0, lat, rv, ev, rdy);
    total++;
    if (lat !== 2 || rv !== 16'd0) begin
      bad++; $display("FAIL clr_mem got lat=%0d res=%h want lat=2 res=0000", lat, rv);
    end
    send(0, 3'b101, 4'd3, 4'd0, 16'd0, lat, rv, ev, rdy);
    total++;
    if (lat !== 1 || rv !== 16'd0) begin
      bad++; $display("FAIL clr_reg got lat=%0d res=%h want lat=1 res=0000", lat, rv);
    end
  endtask

  task automatic test_rst_priority();
    int lat; logic [15:0] rv; logic ev, rdy;
    @(negedge clk);
    rst = 1'b1; iv_a = 1'b1; op = 3'b000; maddr = 4'd6; imm = 16'd9;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0; iv_a = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({busy_a, out_valid_a} !== 2'b00) begin
      bad++; $display("FAIL rst_prio got busy/ov=%b want 00", {busy_a, out_valid_a});
    end
    send(0, 3'b011, 4'd0, 4'd6, 16'd0, lat, rv, ev, rdy);
    total++;
    if (lat !== 2 || rv !== 16'd0) begin
      bad++; $display("FAIL rst_prio_rdm got lat=%0d res=%h want lat=2 res=0000", lat, rv);
    end
  endtask

  task automatic test_lat4();
    int lat; logic [15:0] rv; logic ev, rdy;
    int pulses;
    int first;
    @(negedge clk);
    op = 3'b000; ra = 4'd0; maddr = 4'd3; imm = 16'h1234; iv_b = 1'b1;
    @(posedge clk); #1;
    pulses = 0; first = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (out_valid_b) begin
        pulses++;
        if (first < 0) begin
          first = k; rv = res_b; iv_b = 1'b0;
        end
      end
    end
    iv_b = 1'b0;
    total++;
    if (first !== 4 || pulses !== 1 || rv !== 16'h1234 || busy_b !== 1'b0) begin
      bad++;
      $display("FAIL lat4_sti got lat=%0d pulses=%0d res=%h busy=%b want lat=4 pulses=1 res=1234 busy=0",
               first, pulses, rv, busy_b);
    end
    send(1, 3'b011, 4'd0, 4'd3, 16'd0, lat, rv, ev, rdy);
    total++;
    if (lat !== 4 || rv !== 16'h1234) begin
      bad++; $display("FAIL lat4_rdm got lat=%0d res=%h want lat=4 res=1234", lat, rv);
    end
  endtask

  task automatic test_wrap();
    int lat; logic [15:0] rv; logic ev, rdy;
    send(2, 3'b100, 4'd13, 4'd0, 16'h0077, lat, rv, ev, rdy);
    send(2, 3'b101, 4'd1, 4'd0, 16'd0, lat, rv, ev, rdy);
    total++;
    if (lat !== 1 || rv !== 16'h0077 || ev !== 1'b0) begin
      bad++; $display("FAIL wrap_reg got lat=%0d res=%h err=%b want lat=1 res=0077 err=0", lat, rv, ev);
    end
    send(2, 3'b000, 4'd0, 4'd12, 16'h0042, lat, rv, ev, rdy);
    total++;
    if (lat !== 1 || rv !== 16'h0042) begin
      bad++; $display("FAIL lat1_sti got lat=%0d res=%h want lat=1 res=0042", lat, rv);
    end
    send(2, 3'b011, 4'd0, 4'd2, 16'd0, lat, rv, ev, rdy);
    total++;
    if (lat !== 1 || rv !== 16'h0042) begin
      bad++; $display("FAIL wrap_mem got lat=%0d res=%h want lat=1 res=0042", lat, rv);
    end
  endtask

  initial begin
    test_reset();
    test_sti();
    test_mem_chain();
    test_back_to_back();
    test_reserved();
    test_no_stale();
    test_abort();
    test_rst_priority();
    test_lat4();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
